// File: rtl/apb_slave_bridge_if.sv
// apb_slave_bridge_if: APB request/response bundle between a bus master and the bridge
//   request : psel_i, penable_i, pwrite_i, pstrb_i[MAX_DIM], pwdata_i[BUS_WIDTH], paddr_i[ADDR_WIDTH]
//   response: pready_o, pslverr_o, prdata_o[BUS_WIDTH]
interface apb_slave_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int MAX_DIM    = 4
);
  logic                  psel_i;
  logic                  penable_i;
  logic                  pwrite_i;
  logic [MAX_DIM-1:0]    pstrb_i;
  logic [BUS_WIDTH-1:0]  pwdata_i;
  logic [ADDR_WIDTH-1:0] paddr_i;
  logic                  pready_o;
  logic                  pslverr_o;
  logic [BUS_WIDTH-1:0]  prdata_o;
  modport master (
    output psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
    input  pready_o, pslverr_o, prdata_o
  );
  modport slave (
    input  psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
    output pready_o, pslverr_o, prdata_o
  );
endinterface

// File: rtl/apb_slave_bridge.sv
// apb_slave_bridge: APB slave that scatters/gathers bus words into two operand stores and holds a control register
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   apb (slave modport)    : APB request/response
//   *_a_o / read_data_a_i  : operand A store port (sync read, one-cycle latency); *_b_* likewise for B
//   busy_i, start_o, ctrl_o: engine busy, one-cycle start pulse, control register
module apb_slave_bridge #(
  parameter int DATA_WIDTH  = 32,
  parameter int BUS_WIDTH   = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_DIM     = 4,
  parameter int MATRIX_SIZE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  apb_slave_bridge_if.slave     apb,
  output logic [DATA_WIDTH-1:0] write_data_a_o,
  output logic [ADDR_WIDTH-1:0] addr_a_o,
  output logic                  write_en_a_o,
  input  logic [DATA_WIDTH-1:0] read_data_a_i,
  output logic [DATA_WIDTH-1:0] write_data_b_o,
  output logic [ADDR_WIDTH-1:0] addr_b_o,
  output logic                  write_en_b_o,
  input  logic [DATA_WIDTH-1:0] read_data_b_i,
  input  logic                  busy_i,
  output logic                  start_o,
  output logic [BUS_WIDTH-1:0]  ctrl_o
);
  localparam int N  = BUS_WIDTH / DATA_WIDTH;
  localparam int KW = $clog2(N + 2);
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;
  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [1:0]            region_q, region_d;
  logic [3:0]            base_q, base_d;
  logic                  wr_q, wr_d, err_q, err_d, start_q, start_d;
  logic [MAX_DIM-1:0]    strb_q, strb_d;
  logic [BUS_WIDTH-1:0]  wdata_q, wdata_d, rdata_q, rdata_d, ctrl_q, ctrl_d;
  logic [1:0]            region_in;
  logic [3:0]            base_in;
  logic                  t0, bad, act, we, unused_bits;
  logic [DATA_WIDTH-1:0] wd, rd_sel;
  logic [ADDR_WIDTH-1:0] addr;
  assign region_in   = apb.paddr_i[7:6];
  assign base_in     = apb.paddr_i[5:2];
  assign t0          = state_q == IDLE && apb.psel_i && apb.penable_i;
  assign bad         = region_in == 2'd3 || (region_in == 2'd0 && base_in != 4'd0) ||
                       int'(base_in) + N > MATRIX_SIZE || (apb.pwrite_i && busy_i);
  assign rd_sel      = region_q == 2'd1 ? read_data_a_i : read_data_b_i;
  assign unused_bits = ^{apb.paddr_i[ADDR_WIDTH-1:8], apb.paddr_i[1:0], strb_q};
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    region_d = region_q;
    base_d   = base_q;
    wr_d     = wr_q;
    strb_d   = strb_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    ctrl_d   = ctrl_q;
    start_d  = 1'b0;
    unique case (state_q)
      IDLE: if (t0) begin
        region_d = region_in;
        base_d   = base_in;
        wr_d     = apb.pwrite_i;
        strb_d   = apb.pstrb_i;
        wdata_d  = apb.pwdata_i;
        err_d    = bad;
        k_d      = '0;
        rdata_d  = (region_in == 2'd0 && !apb.pwrite_i && !bad) ? {ctrl_q[BUS_WIDTH-1:2], busy_i, 1'b0} : '0;
        if (region_in == 2'd0 && apb.pwrite_i && !bad) begin
          ctrl_d  = {apb.pwdata_i[BUS_WIDTH-1:2], 2'b00};
          start_d = apb.pwdata_i[0];
        end
        state_d  = (bad || region_in == 2'd0) ? RESP : XFER;
      end
      XFER: begin
        k_d = k_q + 1'b1;
        // read data lags its address by one cycle, so cycle k lands element k-1
        for (int i = 0; i < N; i++)
          if (!wr_q && k_q == KW'(i + 1)) rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_sel;
        if (k_q == KW'(wr_q ? N - 1 : N)) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      k_q      <= '0;
      region_q <= '0;
      base_q   <= '0;
      wr_q     <= 1'b0;
      strb_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      ctrl_q   <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      region_q <= region_d;
      base_q   <= base_d;
      wr_q     <= wr_d;
      strb_q   <= strb_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      ctrl_q   <= ctrl_d;
      start_q  <= start_d;
    end
  end
  always_comb begin
    wd = '0;
    we = 1'b0;
    for (int i = 0; i < N; i++)
      if (k_q == KW'(i)) begin
        wd = wdata_q[i*DATA_WIDTH +: DATA_WIDTH];
        we = strb_q[i];
      end
  end
  assign act            = state_q == XFER && k_q < KW'(N);
  assign addr           = act ? ADDR_WIDTH'(base_q) + ADDR_WIDTH'(k_q) : '0;
  assign addr_a_o       = region_q == 2'd1 ? addr : '0;
  assign addr_b_o       = region_q == 2'd2 ? addr : '0;
  assign write_data_a_o = (act && region_q == 2'd1 && wr_q) ? wd : '0;
  assign write_data_b_o = (act && region_q == 2'd2 && wr_q) ? wd : '0;
  assign write_en_a_o   = act && wr_q && we && region_q == 2'd1;
  assign write_en_b_o   = act && wr_q && we && region_q == 2'd2;
  assign apb.pready_o   = state_q == RESP;
  assign apb.pslverr_o  = state_q == RESP && err_q;
  assign apb.prdata_o   = state_q == RESP ? rdata_q : '0;
  assign start_o        = start_q;
  assign ctrl_o         = ctrl_q;
endmodule

// File: tb/tb_apb_slave_bridge.sv
// tb_apb_slave_bridge: directed checks of the APB bridge against operand-store models with one-cycle read latency
module tb_apb_slave_bridge;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        busy = 1'b0;
  logic        mem_clr = 1'b1;
  logic [31:0] wd_a, wd_b, addr_a, addr_b, rd_a, rd_b;
  logic        we_a, we_b, start;
  logic [63:0] ctrl;
  logic [31:0] mema [16];
  logic [31:0] memb [16];
  int          n_chk = 0;
  int          n_pass = 0;
  logic        we_a_log [32];
  logic        we_b_log [32];
  logic        st_log [32];
  logic [31:0] addr_log [32];
  logic [31:0] wd_log [32];
  logic        pr_after;
  logic [63:0] rdata;
  logic        err;
  int          cyc;
  apb_slave_bridge_if #(.ADDR_WIDTH(32), .BUS_WIDTH(64), .MAX_DIM(4)) apb ();
  apb_slave_bridge #(.DATA_WIDTH(32), .BUS_WIDTH(64), .ADDR_WIDTH(32), .MAX_DIM(4), .MATRIX_SIZE(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .apb(apb),
    .write_data_a_o(wd_a), .addr_a_o(addr_a), .write_en_a_o(we_a), .read_data_a_i(rd_a),
    .write_data_b_o(wd_b), .addr_b_o(addr_b), .write_en_b_o(we_b), .read_data_b_i(rd_b),
    .busy_i(busy), .start_o(start), .ctrl_o(ctrl)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) begin
        mema[i] <= '0;
        memb[i] <= '0;
      end
    end else begin
      if (we_a) mema[addr_a[3:0]] <= wd_a;
      if (we_b) memb[addr_b[3:0]] <= wd_b;
    end
    rd_a <= mema[addr_a[3:0]];
    rd_b <= memb[addr_b[3:0]];
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [63:0] data,
                      input logic [3:0] strb, input bit scramble,
                      output logic [63:0] rd, output logic er, output int n);
    for (int i = 0; i < 32; i++) begin
      we_a_log[i] = 1'b0; we_b_log[i] = 1'b0; st_log[i] = 1'b0; addr_log[i] = '0; wd_log[i] = '0;
    end
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = wr;
    apb.paddr_i = addr; apb.pwdata_i = data; apb.pstrb_i = strb;
    @(posedge clk); #1;
    apb.penable_i = 1'b1;
    n = 0;
    rd = '0;
    er = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (scramble && n == 1) begin
        apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = ~wr;
        apb.paddr_i = 32'h80; apb.pwdata_i = ~data; apb.pstrb_i = 4'h0;
      end
      we_a_log[n] = we_a; we_b_log[n] = we_b; st_log[n] = start;
      addr_log[n] = we_b ? addr_b : addr_a;
      wd_log[n]   = we_b ? wd_b : wd_a;
      if (apb.pready_o) begin
        rd = apb.prdata_o;
        er = apb.pslverr_o;
        break;
      end
      if (n >= 20) begin
        check("pready_timeout", 64'(n), 64'd0);
        break;
      end
    end
    apb.psel_i = 1'b0; apb.penable_i = 1'b0;
    @(posedge clk); #1;
    pr_after = apb.pready_o;
  endtask
  function automatic int count_we(input bit b);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(b ? we_b_log[i] : we_a_log[i]);
    return c;
  endfunction
  initial begin
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    apb.paddr_i = '0; apb.pwdata_i = '0; apb.pstrb_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pready", 64'(apb.pready_o), 64'd0);
    check("rst_pslverr", 64'(apb.pslverr_o), 64'd0);
    check("rst_prdata", apb.prdata_o, 64'd0);
    check("rst_ctrl", ctrl, 64'd0);
    check("rst_we", {62'd0, we_a, we_b}, 64'd0);
    check("rst_start", 64'(start), 64'd0);
    rst_ni = 1'b1;
    mem_clr = 1'b0;
    @(posedge clk); #1;
    xfer(1'b1, 32'h44, 64'h0000000B_0000000A, 4'b0011, 1'b0, rdata, err, cyc);
    check("wrA_cycles", 64'(cyc), 64'd3);
    check("wrA_err", 64'(err), 64'd0);
    check("wrA_k0", {31'd0, we_a_log[1], addr_log[1]}, {31'd0, 1'b1, 32'd1});
    check("wrA_d0", 64'(wd_log[1]), 64'hA);
    check("wrA_k1", {31'd0, we_a_log[2], addr_log[2]}, {31'd0, 1'b1, 32'd2});
    check("wrA_d1", 64'(wd_log[2]), 64'hB);
    check("wrA_no_b", 64'(count_we(1'b1)), 64'd0);
    check("wrA_pready_once", 64'(pr_after), 64'd0);
    check("wrA_prdata", rdata, 64'd0);
    xfer(1'b1, 32'h84, 64'h00000007_00000005, 4'b0011, 1'b0, rdata, err, cyc);
    check("wrB_no_a", 64'(count_we(1'b0)), 64'd0);
    check("wrB_mem", {memb[2], memb[1]}, 64'h00000007_00000005);
    xfer(1'b0, 32'h84, 64'hDEAD_BEEF_0000_0000, 4'b1111, 1'b0, rdata, err, cyc);
    check("rdB_cycles", 64'(cyc), 64'd4);
    check("rdB_data", rdata, 64'h00000007_00000005);
    check("rdB_err", 64'(err), 64'd0);
    check("rdB_no_we", 64'(count_we(1'b0) + count_we(1'b1)), 64'd0);
    xfer(1'b0, 32'h44, 64'd0, 4'b0000, 1'b0, rdata, err, cyc);
    check("rdA_data", rdata, 64'h0000000B_0000000A);
    xfer(1'b1, 32'h7C, 64'h1111_2222_3333_4444, 4'b0011, 1'b0, rdata, err, cyc);
    check("oob_cycles", 64'(cyc), 64'd1);
    check("oob_err", 64'(err), 64'd1);
    check("oob_no_we", 64'(count_we(1'b0)), 64'd0);
    xfer(1'b1, 32'hC0, 64'h1111_2222_3333_4444, 4'b0011, 1'b0, rdata, err, cyc);
    check("reg3_cycles", 64'(cyc), 64'd1);
    check("reg3_err", 64'(err), 64'd1);
    xfer(1'b0, 32'h04, 64'd0, 4'b0000, 1'b0, rdata, err, cyc);
    check("ctlidx_err", {63'd0, err}, 64'd1);
    check("ctlidx_prdata", rdata, 64'd0);
    xfer(1'b1, 32'h78, 64'h0000000F_0000000E, 4'b0011, 1'b0, rdata, err, cyc);
    check("edge_err", 64'(err), 64'd0);
    xfer(1'b0, 32'h78, 64'd0, 4'b0000, 1'b0, rdata, err, cyc);
    check("edge_read", rdata, 64'h0000000F_0000000E);
    xfer(1'b1, 32'h0, 64'h101, 4'b0000, 1'b0, rdata, err, cyc);
    check("ctl_cycles", 64'(cyc), 64'd1);
    check("ctl_start", 64'(st_log[1]), 64'd1);
    check("ctl_start_once", 64'(start), 64'd0);
    check("ctl_value", ctrl, 64'h100);
    busy = 1'b1;
    xfer(1'b1, 32'h0, 64'h301, 4'b0000, 1'b0, rdata, err, cyc);
    check("ctl_busy_err", 64'(err), 64'd1);
    check("ctl_busy_start", 64'(st_log[1]), 64'd0);
    check("ctl_busy_keep", ctrl, 64'h100);
    xfer(1'b0, 32'h0, 64'd0, 4'b0000, 1'b0, rdata, err, cyc);
    check("ctl_rd_busy", rdata, 64'h102);
    xfer(1'b1, 32'h50, 64'h0000_0099_0000_0088, 4'b0011, 1'b0, rdata, err, cyc);
    check("wr_busy_err", 64'(err), 64'd1);
    check("wr_busy_no_we", 64'(count_we(1'b0)), 64'd0);
    busy = 1'b0;
    xfer(1'b0, 32'h0, 64'd0, 4'b0000, 1'b0, rdata, err, cyc);
    check("ctl_rd_idle", rdata, 64'h100);
    xfer(1'b1, 32'h48, 64'h00000022_00000011, 4'b0010, 1'b0, rdata, err, cyc);
    check("strb10_mem", {mema[3], mema[2]}, 64'h00000022_0000000B);
    check("strb10_count", 64'(count_we(1'b0)), 64'd1);
    xfer(1'b1, 32'h50, 64'h00000044_00000033, 4'b1101, 1'b0, rdata, err, cyc);
    check("strb_hi_ign", {mema[5], mema[4]}, 64'h00000000_00000033);
    xfer(1'b1, 32'h60, 64'h00000088_00000077, 4'b0011, 1'b1, rdata, err, cyc);
    check("latch_mem", {mema[9], mema[8]}, 64'h00000088_00000077);
    check("latch_no_b", 64'(memb[8]), 64'd0);
    check("latch_cycles", 64'(cyc), 64'd3);
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b1;
    apb.paddr_i = 32'h68; apb.pwdata_i = 64'h000000BB_000000AA; apb.pstrb_i = 4'b0011;
    @(posedge clk); #1;
    apb.penable_i = 1'b1;
    @(posedge clk); #1;
    check("rstx_pre_we", {31'd0, we_a, addr_a}, {31'd0, 1'b1, 32'd10});
    #2 rst_ni = 1'b0;
    #1;
    check("rstx_we", {62'd0, we_a, we_b}, 64'd0);
    check("rstx_addr_data", {addr_a, wd_a}, 64'd0);
    check("rstx_ctrl", ctrl, 64'd0);
    apb.psel_i = 1'b0; apb.penable_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    check("rstx_mem", {mema[11], mema[10]}, 64'd0);
    check("rstx_kept", {mema[2], mema[1]}, 64'h0000000B_0000000A);
    @(posedge clk); #1;
    xfer(1'b0, 32'h44, 64'd0, 4'b0000, 1'b0, rdata, err, cyc);
    check("post_rst_read", rdata, 64'h0000000B_0000000A);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/apb_slave_bridge.md
APB_SLAVE_BRIDGE -- requirements
Module: apb_slave_bridge

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, operand element width (8/16/32).
REQ-002 SHALL have parameter BUS_WIDTH, default 64, APB data width (16/32/64); N = BUS_WIDTH/DATA_WIDTH elements per bus word, N <= MAX_DIM.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, APB address width and operand-register address width.
REQ-004 SHALL have parameters MAX_DIM, default 4 (strobe width), and MATRIX_SIZE, default 16 (elements per operand).
REQ-005 SHALL have ports: clk_i in 1, the single clock; rst_ni in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: psel_i, penable_i, pwrite_i in 1; pstrb_i in MAX_DIM; pwdata_i in BUS_WIDTH; paddr_i in ADDR_WIDTH (APB request).
REQ-007 SHALL have ports: pready_o out 1; pslverr_o out 1; prdata_o out BUS_WIDTH (APB response).
REQ-008 SHALL have ports: write_data_a_o out DATA_WIDTH; addr_a_o out ADDR_WIDTH; write_en_a_o out 1; read_data_a_i in DATA_WIDTH (operand A store); identical _b_ set for operand B.
REQ-009 SHALL have ports: busy_i in 1, compute engine busy; start_o out 1, one-cycle start pulse; ctrl_o out BUS_WIDTH, control register contents.

Function
REQ-010 SHALL decode region = paddr_i[7:6] (0 control, 1 operand A, 2 operand B, 3 illegal) and element base index b = paddr_i[5:2].
REQ-011 SHALL use FSM states IDLE, XFER, RESP; T0 = first cycle psel_i&&penable_i is seen in IDLE.
REQ-012 SHALL flag error (no store access, no register update) for: region 3; control index != 0; b+N-1 > MATRIX_SIZE-1; any write to region 0/1/2 while busy_i=1 at T0.
REQ-013 SHALL, for control and error accesses, go IDLE->RESP at T0+1.
REQ-014 SHALL, for operand writes, run XFER for T0+1..T0+N; in XFER cycle k (0..N-1) drive addr=b+k, write_data=pwdata_i[k*DATA_WIDTH +: DATA_WIDTH], write_en=pstrb_i[k]; then RESP at T0+N+1.
REQ-015 SHALL, for operand reads, run XFER for T0+1..T0+N+1; drive addr=b+k in XFER cycle k, capture read_data one cycle later into prdata_o[k*DATA_WIDTH +: DATA_WIDTH]; RESP at T0+N+2.
REQ-016 SHALL assert write_en only toward the addressed operand (A or B), never both, and only in XFER.
REQ-017 SHALL register pready_o = (state==RESP), high exactly one cycle per transfer, then return to IDLE.
REQ-018 SHALL drive pslverr_o=1 only in RESP of an errored transfer; prdata_o=0 outside RESP and on errors/writes.
REQ-019 SHALL ignore pstrb_i bits >= N and all strobes on reads and control writes.
REQ-020 SHALL, on non-error control write, store pwdata_i into ctrl_o with bits [1:0] forced 0, and pulse start_o in the RESP cycle when pwdata_i[0]=1.
REQ-021 SHALL return on control read {ctrl_o[BUS_WIDTH-1:2], busy_i, 1'b0}.
REQ-022 SHALL latch paddr_i, pwrite_i, pstrb_i, pwdata_i at T0; later bus changes or psel_i deassertion do not alter an in-flight transfer.
REQ-023 SHALL not start a new transfer in the RESP cycle; back-to-back accesses begin at earliest the cycle after RESP.

Reset
REQ-024 SHALL, on rst_ni=0 (asynchronous, any state incl. mid-XFER), force IDLE; pready_o, pslverr_o, start_o, write_en_a_o, write_en_b_o = 0; prdata_o, ctrl_o, addr and write_data outputs = 0.
REQ-025 SHALL leave elements already written before reset unchanged; remaining elements of an aborted transfer are not written.

Verification (DATA_WIDTH=32, BUS_WIDTH=64, N=2)
REQ-026 Write A, paddr=0x44, pwdata=0x0000000B_0000000A, pstrb=0b11 -> write_en_a at T0+1 (addr 1, 0xA), T0+2 (addr 2, 0xB); pready at T0+3, pslverr=0.
REQ-027 Read B, paddr=0x84, store B[1]=5, B[2]=7 -> pready at T0+4, prdata=0x00000007_00000005, pslverr=0.
REQ-028 Write A, paddr=0x7C (b=15) -> no write_en, pready at T0+1 with pslverr=1; same for paddr=0xC0.
REQ-029 Control write pwdata=0x101 with busy_i=0 -> start_o pulse at T0+1, ctrl_o=0x100; repeat with busy_i=1 -> pslverr=1, no start_o, ctrl_o unchanged; control read with busy_i=1 -> prdata=0x102.
REQ-030 Write A with pstrb=0b10 -> only addr b+1 written; assert rst_ni=0 at T0+1 of another write -> outputs zero immediately, IDLE, no write at T0+2.
